updown_ctrl: RTL and testbench

UPDOWN_CTRL -- requirements
Module: updown_ctrl

---
 rtl/updown_ctrl.sv | 133 +++++++++++++
 tb/tb_updown_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_ctrl.sv
// Sequencer for an external 4-bit up/down counter: paces step enables every
// TICK_DIV cycles and handles limits, pause, reverse and stop commands.
module updown_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       rev,
    input  logic       dir_req,
    input  logic       mode,
    input  logic [3:0] lo_lim,
    input  logic [3:0] hi_lim,
    input  logic [3:0] count_in,
    output logic       ud,
    output logic       en,
    output logic [1:0] state,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [7:0] TICK_MAX = 8'(TICK_DIV - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_tick;
    logic [7:0] w_tick_nxt;
    logic       r_ud;
    logic       w_ud_nxt;
    logic       r_en;
    logic       w_en_nxt;
    logic       w_cfg_err;
    logic       w_tick;
    logic       w_at_lim;
    logic [7:0] w_tick_inc;

    assign w_cfg_err  = (lo_lim > hi_lim);
    assign w_tick     = (r_tick == TICK_MAX);
    assign w_tick_inc = w_tick ? 8'd0 : (r_tick + 8'd1);
    assign w_at_lim   = r_ud ? (count_in >= hi_lim) : (count_in <= lo_lim);

    // Next-state decode; command priority is stop > pause > rev > start.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_ud_nxt    = r_ud;
        w_en_nxt    = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_tick_nxt  = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !w_cfg_err) begin
                        w_state_nxt = ST_RUN;
                        w_tick_nxt  = 8'd0;
                        w_ud_nxt    = dir_req;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // The pausing cycle still counts, so resume picks up one step later.
                        w_state_nxt = ST_PAUSE;
                        w_tick_nxt  = w_tick_inc;
                    end else if (rev) begin
                        w_ud_nxt = ~r_ud;
                    end else if (w_tick) begin
                        w_tick_nxt = 8'd0;
                        if (w_cfg_err) begin
                            w_state_nxt = ST_DONE;
                        end else if (w_at_lim) begin
                            if (mode) begin
                                w_ud_nxt = ~r_ud;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            w_en_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = ST_RUN;
                    end else if (rev) begin
                        w_ud_nxt = ~r_ud;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_tick_nxt  = 8'd0;
                end
            endcase
        end
    end

    // State, tick counter and registered counter controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tick  <= 8'd0;
            r_ud    <= 1'b1;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_ud    <= w_ud_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign ud      = r_ud;
    assign en      = r_en;
    assign state   = r_state;
    assign done    = (r_state == ST_DONE);
    assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_updown_ctrl.sv
// Scoreboard bench for updown_ctrl: directed scenarios push expected en pulses
// and per-cycle status into queues; a negedge monitor pops and compares.
module tb_updown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       rev = 1'b0;
    logic       dir_req = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] lo_lim = 4'd0;
    logic [3:0] hi_lim = 4'd15;
    logic [3:0] count_in;
    logic       ud;
    logic       en;
    logic [1:0] state;
    logic       done;
    logic       cfg_err;

    logic [3:0] cnt = 4'd0;
    logic       cnt_load = 1'b0;
    logic [3:0] cnt_val = 4'd0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       end_req = 1'b0;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       en;
        logic       ud;
        logic       dn;
        logic       ce;
        string      tag;
    } exp_t;

    exp_t q_exp[$];
    int   q_pulse[$];

    updown_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .rev      (rev),
        .dir_req  (dir_req),
        .mode     (mode),
        .lo_lim   (lo_lim),
        .hi_lim   (hi_lim),
        .count_in (count_in),
        .ud       (ud),
        .en       (en),
        .state    (state),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    assign count_in = cnt;

    // Cycle index: after edge N the bench is in cycle N.
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the external up/down counter driven by en/ud.
    always @(posedge clk) begin
        if (cnt_load) cnt <= cnt_val;
        else if (en) cnt <= ud ? cnt + 4'd1 : cnt - 4'd1;
    end

    // Monitor: pops expected status entries and en pulses and compares.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q_exp.size() > 0 && q_exp[0].cyc <= cyc) begin
            e = q_exp.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s missed: want check at cyc=%0d got none (now %0d)", e.tag, e.cyc, cyc);
            end else if ({state, en, ud, done, cfg_err} !== {e.st, e.en, e.ud, e.dn, e.ce}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got st=%b en=%b ud=%b done=%b cfg_err=%b want st=%b en=%b ud=%b done=%b cfg_err=%b",
                         e.tag, cyc, state, en, ud, done, cfg_err, e.st, e.en, e.ud, e.dn, e.ce);
            end
        end
        while (q_pulse.size() > 0 && q_pulse[0] < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL en_missing want pulse at cyc=%0d got none (now %0d)", q_pulse[0], cyc);
            void'(q_pulse.pop_front());
        end
        if (en) begin
            n_checks++;
            if (q_pulse.size() > 0 && q_pulse[0] == cyc) begin
                void'(q_pulse.pop_front());
            end else begin
                n_fail++;
                $display("FAIL en_unexpected got en=1 at cyc=%0d want next pulse at %0d",
                         cyc, (q_pulse.size() > 0) ? q_pulse[0] : -1);
            end
        end
        if (end_req) begin
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s never reached: want cyc=%0d got end at %0d", e.tag, e.cyc, cyc);
            end
            while (q_pulse.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL en_missing want pulse at cyc=%0d got end at %0d", q_pulse[0], cyc);
                void'(q_pulse.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic s, input logic sp, input logic p, input logic r);
        start = s; stop = sp; pause = p; rev = r;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; pause = 1'b0; rev = 1'b0;
    endtask

    task automatic load_cnt(input logic [3:0] v);
        cnt_val  = v;
        cnt_load = 1'b1;
        @(posedge clk);
        #1;
        cnt_load = 1'b0;
    endtask

    task automatic expect_st(input int c, input logic [1:0] st, input logic e, input logic u,
                             input logic d, input logic ce, input string tag);
        exp_t x;
        x = '{c, st, e, u, d, ce, tag};
        q_exp.push_back(x);
    endtask

    initial begin : stim
        int s;
        // Reset
        rst = 1'b1;
        wait_cyc(3);
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        wait_cyc(1);

        // One-shot up count 0..3 then DONE
        lo_lim = 4'd0; hi_lim = 4'd3; mode = 1'b0; dir_req = 1'b1;
        load_cnt(4'd0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        q_pulse.push_back(s + 4); q_pulse.push_back(s + 8); q_pulse.push_back(s + 12);
        expect_st(s,      S_RUN,  1'b0, 1'b1, 1'b0, 1'b0, "a_start");
        expect_st(s + 3,  S_RUN,  1'b0, 1'b1, 1'b0, 1'b0, "a_pre_en");
        expect_st(s + 4,  S_RUN,  1'b1, 1'b1, 1'b0, 1'b0, "a_first_en");
        expect_st(s + 15, S_RUN,  1'b0, 1'b1, 1'b0, 1'b0, "a_last_run");
        expect_st(s + 17, S_DONE, 1'b0, 1'b1, 1'b1, 1'b0, "a_done");
        expect_st(s + 21, S_DONE, 1'b0, 1'b1, 1'b1, 1'b0, "a_done_hold");
        wait_cyc(22);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "a_stop");

        // Bounce between 2 and 4
        lo_lim = 4'd2; hi_lim = 4'd4; mode = 1'b1; dir_req = 1'b1;
        load_cnt(4'd2);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        q_pulse.push_back(s + 4);  q_pulse.push_back(s + 8);  q_pulse.push_back(s + 16);
        q_pulse.push_back(s + 20); q_pulse.push_back(s + 28);
        expect_st(s + 11, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, "b_up");
        expect_st(s + 12, S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, "b_flip_down");
        expect_st(s + 16, S_RUN, 1'b1, 1'b0, 1'b0, 1'b0, "b_down_en");
        expect_st(s + 23, S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, "b_down");
        expect_st(s + 24, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, "b_flip_up");
        expect_st(s + 28, S_RUN, 1'b1, 1'b1, 1'b0, 1'b0, "b_up_en");
        wait_cyc(29);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "b_stop");

        // Pause at 6, rev twice while paused, resume at 20
        lo_lim = 4'd0; hi_lim = 4'd15; mode = 1'b0; dir_req = 1'b1;
        load_cnt(4'd0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        q_pulse.push_back(s + 4); q_pulse.push_back(s + 22); q_pulse.push_back(s + 26);
        expect_st(s + 6,  S_PAUSE, 1'b0, 1'b1, 1'b0, 1'b0, "c_paused");
        expect_st(s + 10, S_PAUSE, 1'b0, 1'b0, 1'b0, 1'b0, "c_rev");
        expect_st(s + 12, S_PAUSE, 1'b0, 1'b1, 1'b0, 1'b0, "c_rev_back");
        expect_st(s + 19, S_PAUSE, 1'b0, 1'b1, 1'b0, 1'b0, "c_still_paused");
        expect_st(s + 20, S_RUN,   1'b0, 1'b1, 1'b0, 1'b0, "c_resume");
        expect_st(s + 22, S_RUN,   1'b1, 1'b1, 1'b0, 1'b0, "c_en_after_resume");
        wait_cyc(5);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(3);
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        wait_cyc(1);
        cmd(1'b0, 1'b0, 1'b0, 1'b1);
        wait_cyc(7);
        cmd(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(7);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "c_stop");

        // stop and start together while running
        load_cnt(4'd0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        q_pulse.push_back(s + 4);
        expect_st(s + 4, S_RUN, 1'b1, 1'b1, 1'b0, 1'b0, "d_en");
        wait_cyc(5);
        cmd(1'b1, 1'b1, 1'b0, 1'b0);
        expect_st(cyc,     S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "d_stop_wins");
        expect_st(cyc + 4, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "d_idle_hold");
        wait_cyc(6);

        // Inverted limits block start until fixed
        lo_lim = 4'd9; hi_lim = 4'd5;
        load_cnt(4'd9);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        expect_st(s,     S_IDLE, 1'b0, 1'b1, 1'b0, 1'b1, "e_cfg_err");
        expect_st(s + 1, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b1, "e_start_ignored");
        wait_cyc(2);
        hi_lim = 4'd12;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        expect_st(cyc, S_RUN, 1'b0, 1'b1, 1'b0, 1'b0, "e_start_ok");
        wait_cyc(1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "e_stop");

        // Reset mid-run (overriding a start), then restart
        lo_lim = 4'd0; hi_lim = 4'd15; mode = 1'b0; dir_req = 1'b0;
        load_cnt(4'd10);
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        s = cyc;
        q_pulse.push_back(s + 4);
        expect_st(s, S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, "f_run_down");
        wait_cyc(5);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        expect_st(cyc, S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, "f_reset");
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        q_pulse.push_back(cyc + 4);
        expect_st(cyc, S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, "f_restart");
        wait_cyc(5);
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(cyc, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, "f_stop_ud_hold");

        wait_cyc(2);
        end_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
